// File: rtl/ula_divisor_seq_pkg.sv
// Shared definitions for the nRisc ULA sequential divider: FSM encodings and default data width.
package ula_divisor_seq_pkg;
  localparam int ULA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_estagio.sv
// One restoring-division step: trial subtract of the divisor from the shifted remainder.
module div_estagio #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  logic [WIDTH:0] t;

  // Two's-complement subtract: invert B, carry-in 1; extra MSB is the borrow.
  assign t      = {1'b0, rs} + {1'b1, ~d} + {{WIDTH{1'b0}}, 1'b1};
  assign q_bit  = ~t[WIDTH];
  assign r_next = q_bit ? t[WIDTH-1:0] : rs;
endmodule

// File: rtl/ula_divisor_seq.sv
// Multicycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module ula_divisor_seq
  import ula_divisor_seq_pkg::*;
#(
  parameter int WIDTH = ULA_W,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_q, q_q, d_q, rs, r_nx;
  logic             q_bit, dz_q;
  logic             accept, last;

  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign rs     = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign busy   = (state == ST_CALC);

  div_estagio #(.WIDTH(WIDTH)) u_estagio (
    .rs    (rs),
    .d     (d_q),
    .r_next(r_nx),
    .q_bit (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_nx = (divisor == '0) ? ST_DONE : ST_CALC;
        else        state_nx = ST_IDLE;
      end
      ST_CALC: if (last) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // A zero divisor preloads the saturated result and bypasses CALC entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      r_q  <= '0;
      q_q  <= '0;
      d_q  <= '0;
      dz_q <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      d_q <= divisor;
      if (divisor == '0) begin
        r_q  <= dividendo;
        q_q  <= '1;
        dz_q <= 1'b1;
      end else begin
        r_q  <= '0;
        q_q  <= dividendo;
        dz_q <= 1'b0;
      end
    end else if (state == ST_CALC) begin
      r_q <= r_nx;
      q_q <= {q_q[WIDTH-2:0], q_bit};
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Results publish on leaving DONE, so a start taken in DONE still sees the old result out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quociente <= '0;
      resto     <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        quociente <= q_q;
        resto     <= r_q;
        div_zero  <= dz_q;
      end else if (accept) begin
        div_zero <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ula_divisor_seq.sv
// Self-checking bench for ula_divisor_seq: behavioural /,% model plus directed literal cases.
module tb_ula_divisor_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividendo = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quociente, resto;
  logic         busy, done, div_zero;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ula_divisor_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividendo(dividendo),
    .divisor  (divisor),
    .quociente(quociente),
    .resto    (resto),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edges remaining until done, plus the pending result from / and %.
  int           m_rem, old;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_dz, p_dz, m_done, m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_q = '0; m_r = '0; m_dz = 0; m_done = 0; m_busy = 0;
      p_q = '0; p_r = '0; p_dz = 0;
    end else begin
      old = m_rem;
      m_done = (old == 1);
      if (old == 1) begin m_q = p_q; m_r = p_r; m_dz = p_dz; end
      if (old > 0) m_rem = old - 1;
      if (start && old <= 1) begin
        if (divisor == 0) begin
          p_q = '1; p_r = dividendo; p_dz = 1; m_rem = 1;
        end else begin
          p_q = dividendo / divisor; p_r = dividendo % divisor; p_dz = 0; m_rem = W + 1;
        end
        if (old != 1) m_dz = 0;
      end
      m_busy = (m_rem >= 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_done", done, m_done);
      chk("cyc_busy", busy, m_busy);
      chk("cyc_quociente", quociente, m_q);
      chk("cyc_resto", resto, m_r);
      chk("cyc_div_zero", div_zero, m_dz);
    end
  end

  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividendo = a; divisor = b;
    @(posedge clk); #2;
    start = 1'b0; dividendo = $urandom; divisor = $urandom;
  endtask

  // Waits for done; lat/nbusy < 0 skips those checks. Bound of 30 cycles.
  task automatic wait_done(input int eq, input int er, input int edz, input int lat, input int nbusy);
    int k, nb;
    bit seen;
    seen = 0; nb = 0;
    for (k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        seen = 1;
        chk("lit_quociente", quociente, eq);
        chk("lit_resto", resto, er);
        chk("lit_div_zero", div_zero, edz);
        if (lat >= 0) chk("lit_latency", k - 1, lat);
        if (nbusy >= 0) chk("lit_busy_cycles", nb, nbusy);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    @(posedge clk); #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quociente", quociente, 0);
    chk("rst_resto", resto, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    pulse_start(200, 7);  wait_done(28, 4, 0, W + 1, W);
    pulse_start(255, 1);  wait_done(255, 0, 0, W + 1, W);
    pulse_start(5, 9);    wait_done(0, 5, 0, W + 1, W);
    pulse_start(0, 3);    wait_done(0, 0, 0, W + 1, W);
    pulse_start(77, 0);   wait_done(255, 77, 1, 1, 0);
    pulse_start(255, 254); wait_done(1, 1, 0, W + 1, W);

    // start during CALC is ignored
    pulse_start(100, 10);
    @(posedge clk); @(posedge clk); #2;
    pulse_start(9, 3);
    wait_done(10, 0, 0, -1, -1);

    // start sampled on the DONE edge is taken back-to-back
    pulse_start(100, 10);
    repeat (W) @(posedge clk);
    #2;
    pulse_start(9, 3);
    wait_done(10, 0, 0, -1, -1);
    wait_done(3, 0, 0, -1, -1);

    // reset mid-CALC aborts immediately with no trailing done
    pulse_start(200, 7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_quociente", quociente, 0);
    chk("abort_resto", resto, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    @(posedge clk); #2;
    pulse_start(200, 7);  wait_done(28, 4, 0, W + 1, W);

    // random sweep with starts at arbitrary times, including while busy
    for (int i = 0; i < 15000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0:       dividendo = '1;
        1:       dividendo = '0;
        default: dividendo = W'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       divisor = '0;
        1:       divisor = 8'd1;
        2:       divisor = '1;
        default: divisor = W'($urandom);
      endcase
      @(posedge clk); #2;
    end
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
